// File: rtl/tff_toggle_monitor.sv
// rtl/tff_toggle_monitor.sv - toggle counter with threshold report handshake; optional TOGGLE_SYNC_EN input synchronizer
module tff_toggle_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             t_in,
  input  logic             en,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] cnt,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic             t_src;
  logic             t_s_q;
  logic             t_q_q;
  logic             tog;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             accept;

`ifdef TOGGLE_SYNC_EN
  // t_in comes from an unrelated clock domain: two flops before the sample stage
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= t_in;
      sync2_q <= sync1_q;
    end
  end

  assign t_src = sync2_q;
`else
  assign t_src = t_in;
`endif

  // t_q follows t_s in every state so enabling never sees a stale edge
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t_s_q <= 1'b0;
      t_q_q <= 1'b0;
    end else begin
      t_s_q <= t_src;
      t_q_q <= t_s_q;
    end
  end

  assign tog     = t_s_q ^ t_q_q;
  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign hit     = tog && (thresh != '0) && (cnt_inc == thresh);
  assign accept  = rpt_valid_q && rpt_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rpt_count_d = rpt_count_q;
    rpt_valid_d = rpt_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        rpt_valid_d = 1'b0;
        ovf_d       = 1'b0;
        if (en) state_d = ST_COUNT;
      end
      ST_COUNT, ST_HOLD: begin
        if (!en) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          rpt_valid_d = 1'b0;
          ovf_d       = 1'b0;
        end else if (hit) begin
          cnt_d = '0;
          // a new report can only be loaded when the slot is empty or being accepted now
          if ((state_q == ST_COUNT) || accept) begin
            rpt_count_d = thresh;
            rpt_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          if (tog) cnt_d = cnt_inc;
          if ((state_q == ST_HOLD) && accept) begin
            rpt_valid_d = 1'b0;
            state_d     = ST_COUNT;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        rpt_valid_d = 1'b0;
        ovf_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rpt_count_q <= '0;
      rpt_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rpt_count_q <= rpt_count_d;
      rpt_valid_q <= rpt_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cnt       = cnt_q;
  assign rpt_valid = rpt_valid_q;
  assign rpt_count = rpt_count_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// tb/tb_tff_toggle_monitor.sv - directed and random checks of tff_toggle_monitor (CNT_W=8 and CNT_W=4)
module tb_tff_toggle_monitor;

`ifdef TOGGLE_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int LAT = S + 1;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       t_in;
  logic       en;
  logic       rpt_ready;
  logic [7:0] thresh;
  logic [3:0] thresh4;

  logic [7:0] cnt, rpt_count;
  logic       rpt_valid, ovf, busy;
  logic [3:0] cnt4, rpt_count4;
  logic       rpt_valid4, ovf4, busy4;

  always #5 clk = ~clk;

  tff_toggle_monitor #(.CNT_W(8)) dut (
    .clk(clk), .clr_n(clr_n), .t_in(t_in), .en(en), .thresh(thresh),
    .cnt(cnt), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_count(rpt_count), .ovf(ovf), .busy(busy)
  );

  tff_toggle_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .clr_n(clr_n), .t_in(t_in), .en(en), .thresh(thresh4),
    .cnt(cnt4), .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready),
    .rpt_count(rpt_count4), .ovf(ovf4), .busy(busy4)
  );

  int ncmp = 0;
  int nmis = 0;

  // reference model: index 0 = 8-bit instance, 1 = 4-bit instance
  int m_mod[2] = '{256, 16};
  int m_cnt[2];
  int m_rc[2];
  bit m_val[2];
  bit m_ovf[2];
  bit m_busy[2];
  bit hist[0:4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rc[i] = 0; m_val[i] = 0; m_ovf[i] = 0; m_busy[i] = 0;
    end
    for (int j = 0; j < 5; j++) hist[j] = 0;
  endtask

  task automatic model_edge();
    bit tg;
    int th;
    bit acc;
    tg = (hist[S] != hist[S+1]);
    for (int i = 0; i < 2; i++) begin
      th  = (i == 0) ? int'(thresh) : int'(thresh4);
      acc = m_val[i] && rpt_ready;
      if (!m_busy[i] || !en) begin
        m_busy[i] = m_busy[i] ? 1'b0 : en;
        m_cnt[i] = 0; m_val[i] = 0; m_ovf[i] = 0;
      end else if (tg && th != 0 && ((m_cnt[i] + 1) % m_mod[i]) == th) begin
        m_cnt[i] = 0;
        if (!m_val[i] || acc) begin
          m_rc[i] = th; m_val[i] = 1;
        end else begin
          m_ovf[i] = 1;
        end
      end else begin
        if (tg) m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
        if (acc) m_val[i] = 0;
      end
    end
    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = t_in;
  endtask

  task automatic check_all();
    chk("cnt",        32'(cnt),        m_cnt[0]);
    chk("rpt_valid",  32'(rpt_valid),  32'(m_val[0]));
    chk("rpt_count",  32'(rpt_count),  m_rc[0]);
    chk("ovf",        32'(ovf),        32'(m_ovf[0]));
    chk("busy",       32'(busy),       32'(m_busy[0]));
    chk("cnt4",       32'(cnt4),       m_cnt[1]);
    chk("rpt_valid4", 32'(rpt_valid4), 32'(m_val[1]));
    chk("rpt_count4", 32'(rpt_count4), m_rc[1]);
    chk("ovf4",       32'(ovf4),       32'(m_ovf[1]));
    chk("busy4",      32'(busy4),      32'(m_busy[1]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic toggles(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      t_in = ~t_in;
      repeat (gap) tick();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cnt"},   32'(cnt),       0);
    chk({tag, "_valid"}, 32'(rpt_valid), 0);
    chk({tag, "_rc"},    32'(rpt_count), 0);
    chk({tag, "_ovf"},   32'(ovf),       0);
    chk({tag, "_busy"},  32'(busy),      0);
  endtask

  initial begin
    int nv;
    clr_n = 1'b0; t_in = 1'b0; en = 1'b0; rpt_ready = 1'b0; thresh = 8'd0; thresh4 = 4'd0;
    model_reset();

    // reset held 7ns while t_in toggles
    #1 t_in = 1'b1;
    #2 t_in = 1'b0;
    #2 t_in = 1'b1;
    #1 check_zero("rst");
    #1 clr_n = 1'b1;
    model_reset();
    toggles(3, 2);
    repeat (4) tick();
    chk("t1_cnt", 32'(cnt), 0);
    chk("t1_busy", 32'(busy), 0);

    // threshold 4, consumer always ready, toggle every 10 clocks
    en = 1'b1; thresh = 8'd4; rpt_ready = 1'b1;
    tick();
    nv = 0;
    for (int t = 0; t < 4; t++) begin
      t_in = ~t_in;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (t == 0 && c < LAT) chk("t2_latency_hold", 32'(cnt), 0);
        if (t == 0 && c == LAT) chk("t2_latency_step", 32'(cnt), 1);
        if (rpt_valid) begin
          nv++;
          chk("t2_rc", 32'(rpt_count), 4);
        end
      end
    end
    chk("t2_valid_cycles", nv, 1);
    chk("t2_cnt", 32'(cnt), 0);
    chk("t2_ovf", 32'(ovf), 0);

    // threshold 3, consumer stalled: second hit overflows
    thresh = 8'd3; rpt_ready = 1'b0;
    toggles(6, 2);
    repeat (LAT) tick();
    chk("t3_valid", 32'(rpt_valid), 1);
    chk("t3_rc", 32'(rpt_count), 3);
    chk("t3_ovf", 32'(ovf), 1);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("t3_valid_drop", 32'(rpt_valid), 0);
    chk("t3_ovf_sticky", 32'(ovf), 1);
    tick();

    // threshold 1, toggling every cycle with ready: back-to-back reports
    en = 1'b0; tick();
    en = 1'b1; tick();
    thresh = 8'd1; rpt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      t_in = ~t_in;
      tick();
      if (i >= LAT) begin
        chk("t4_valid", 32'(rpt_valid), 1);
        chk("t4_rc", 32'(rpt_count), 1);
        chk("t4_ovf", 32'(ovf), 0);
      end
    end
    repeat (LAT + 2) tick();

    // threshold 0: 4-bit counter wraps after 16 toggles
    en = 1'b0; tick();
    en = 1'b1; tick();
    thresh = 8'd0; thresh4 = 4'd0;
    nv = 0;
    for (int i = 0; i < 17; i++) begin
      t_in = ~t_in;
      tick();
      if (rpt_valid4 || rpt_valid) nv++;
    end
    repeat (LAT) begin
      tick();
      if (rpt_valid4 || rpt_valid) nv++;
    end
    chk("t5_cnt4", 32'(cnt4), 1);
    chk("t5_cnt8", 32'(cnt), 17);
    chk("t5_no_report", nv, 0);

    // disable mid-count, then async reset while a report is pending
    en = 1'b0; tick();
    en = 1'b1; tick();
    toggles(2, 2);
    repeat (LAT) tick();
    chk("t6_cnt2", 32'(cnt), 2);
    en = 1'b0;
    tick();
    chk("t6_cnt_clr", 32'(cnt), 0);
    chk("t6_busy_clr", 32'(busy), 0);
    en = 1'b1; tick();
    thresh = 8'd1; rpt_ready = 1'b0;
    toggles(1, LAT + 1);
    chk("t6_hold_valid", 32'(rpt_valid), 1);
    #1 clr_n = 1'b0;
    #1 check_zero("t6_async");
    #1 clr_n = 1'b1;
    model_reset();

    // randomized traffic against the model
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) t_in = ~t_in;
      en = ($urandom_range(0, 39) != 0);
      rpt_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) thresh = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) thresh4 = 4'($urandom_range(0, 5));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
